// File: rtl/arcade_input_pkg.sv
// Shared constants and helpers for the arcade player-input front end.
package arcade_input_pkg;

    // ps2_key field positions
    localparam int unsigned PS2_TOG     = 10;
    localparam int unsigned PS2_PRESSED = 9;
    localparam int unsigned PS2_EXT     = 8;

    // Fire buttons reachable from the keyboard
    localparam int unsigned KEY_BUTTONS = 3;

    // Fixed joystick bit positions
    localparam int unsigned JOY_R    = 0;
    localparam int unsigned JOY_L    = 1;
    localparam int unsigned JOY_D    = 2;
    localparam int unsigned JOY_U    = 3;
    localparam int unsigned JOY_BTN0 = 4;

    // Player 0 scancodes (arrows are E0-prefixed)
    localparam logic [7:0] SC_P0_UP      = 8'h75;
    localparam logic [7:0] SC_P0_DOWN    = 8'h72;
    localparam logic [7:0] SC_P0_LEFT    = 8'h6B;
    localparam logic [7:0] SC_P0_RIGHT   = 8'h74;
    localparam logic [7:0] SC_P0_B0      = 8'h14;
    localparam logic [7:0] SC_P0_B1      = 8'h11;
    localparam logic [7:0] SC_P0_B2      = 8'h29;
    localparam logic [7:0] SC_P0_START   = 8'h16;
    localparam logic [7:0] SC_P0_COIN    = 8'h2E;
    localparam logic [7:0] SC_P0_PAUSE   = 8'h4D;
    localparam logic [7:0] SC_P0_SERVICE = 8'h46;

    // Player 1 scancodes
    localparam logic [7:0] SC_P1_UP      = 8'h2D;
    localparam logic [7:0] SC_P1_DOWN    = 8'h2B;
    localparam logic [7:0] SC_P1_LEFT    = 8'h23;
    localparam logic [7:0] SC_P1_RIGHT   = 8'h34;
    localparam logic [7:0] SC_P1_B0      = 8'h1C;
    localparam logic [7:0] SC_P1_B1      = 8'h1B;
    localparam logic [7:0] SC_P1_B2      = 8'h15;
    localparam logic [7:0] SC_P1_START   = 8'h1E;
    localparam logic [7:0] SC_P1_COIN    = 8'h36;
    localparam logic [7:0] SC_P1_SERVICE = 8'h45;

    // Keyboard-held state for one player
    typedef struct packed {
        logic [3:0]             dir;
        logic [KEY_BUTTONS-1:0] btn;
        logic                   start;
        logic                   coin;
        logic                   pause;
        logic                   service;
    } key_state_t;

    // Joystick bit positions that move with the button count
    function automatic int unsigned joy_start(input int unsigned nb);
        return JOY_BTN0 + nb;
    endfunction

    function automatic int unsigned joy_coin(input int unsigned nb);
        return JOY_BTN0 + nb + 1;
    endfunction

    function automatic int unsigned joy_pause(input int unsigned nb);
        return JOY_BTN0 + nb + 2;
    endfunction

    function automatic int unsigned joy_service(input int unsigned nb);
        return JOY_BTN0 + nb + 3;
    endfunction

    // Base bit of player p within a packed per-player bus
    function automatic int unsigned player_base(input int unsigned p, input int unsigned w);
        return p * w;
    endfunction

endpackage

// File: rtl/input_button_shaper.sv
// One fire button: plain pass-through or vblank-locked autofire.
module input_button_shaper #(
    parameter logic [3:0] AUTOFIRE_FRAMES = 4'd2
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic raw,
    input  logic en,
    input  logic vblank_rise,
    output logic shaped
);

    logic       raw_q;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [3:0] cnt_inc;
    logic       shaped_next;

    // Next-state: release dominates, then mode, then press, then frame count
    always_comb begin
        cnt_next    = cnt;
        shaped_next = shaped;
        cnt_inc     = cnt + 4'd1;
        if (!raw) begin
            shaped_next = 1'b0;
            cnt_next    = '0;
        end else if (!en) begin
            shaped_next = 1'b1;
            cnt_next    = '0;
        end else if (!raw_q) begin
            shaped_next = 1'b1;
            cnt_next    = '0;
        end else if (vblank_rise) begin
            if (cnt_inc >= AUTOFIRE_FRAMES) begin
                shaped_next = ~shaped;
                cnt_next    = '0;
            end else begin
                cnt_next = cnt_inc;
            end
        end
    end

    // State and registered output
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            raw_q  <= 1'b0;
            cnt    <= '0;
            shaped <= 1'b0;
        end else begin
            raw_q  <= raw;
            cnt    <= cnt_next;
            shaped <= shaped_next;
        end
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 key events and MiSTer joystick words into shaped per-player controls.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS       = 2,
    parameter int unsigned NUM_BUTTONS       = 3,
    parameter int unsigned JOY_WIDTH         = 11,
    parameter logic [15:0] COIN_PULSE_CYCLES = 16'd4096,
    parameter logic [3:0]  AUTOFIRE_FRAMES   = 4'd2,
    parameter bit          PAUSE_TOGGLE      = 1'b1
) (
    input  logic                               clk_sys,
    input  logic                               RESET,
    input  logic [10:0]                        ps2_key,
    input  logic [NUM_PLAYERS*JOY_WIDTH-1:0]   joystick,
    input  logic                               vblank,
    input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] autofire_en,
    output logic [NUM_PLAYERS*4-1:0]           out_dir,
    output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] out_buttons,
    output logic [NUM_PLAYERS-1:0]             out_start,
    output logic [NUM_PLAYERS-1:0]             out_coin,
    output logic [NUM_PLAYERS-1:0]             out_pause,
    output logic [NUM_PLAYERS-1:0]             out_service
);

    logic       old_tog;
    logic       armed;
    logic       vblank_q;
    logic       vblank_rise;
    logic       key_ev;
    logic       key_ext;
    logic       key_prs;
    key_state_t kb_p0;
    key_state_t kb_p1;
    key_state_t kb_p0_next;
    key_state_t kb_p1_next;

    assign vblank_rise = vblank & ~vblank_q;
    assign key_ext     = ps2_key[PS2_EXT];
    assign key_prs     = ps2_key[PS2_PRESSED];

    // Decode one PS/2 event into the keyboard-held state
    always_comb begin
        kb_p0_next = kb_p0;
        kb_p1_next = kb_p1;
        key_ev     = armed && (ps2_key[PS2_TOG] != old_tog);
        if (key_ev) begin
            case (ps2_key[7:0])
                SC_P0_UP:      if (key_ext)  kb_p0_next.dir[JOY_U] = key_prs;
                SC_P0_DOWN:    if (key_ext)  kb_p0_next.dir[JOY_D] = key_prs;
                SC_P0_LEFT:    if (key_ext)  kb_p0_next.dir[JOY_L] = key_prs;
                SC_P0_RIGHT:   if (key_ext)  kb_p0_next.dir[JOY_R] = key_prs;
                SC_P0_B0:                    kb_p0_next.btn[0]     = key_prs;
                SC_P0_B1:                    kb_p0_next.btn[1]     = key_prs;
                SC_P0_B2:      if (!key_ext) kb_p0_next.btn[2]     = key_prs;
                SC_P0_START:   if (!key_ext) kb_p0_next.start      = key_prs;
                SC_P0_COIN:    if (!key_ext) kb_p0_next.coin       = key_prs;
                SC_P0_PAUSE:   if (!key_ext) kb_p0_next.pause      = key_prs;
                SC_P0_SERVICE: if (!key_ext) kb_p0_next.service    = key_prs;
                SC_P1_UP:      if (!key_ext) kb_p1_next.dir[JOY_U] = key_prs;
                SC_P1_DOWN:    if (!key_ext) kb_p1_next.dir[JOY_D] = key_prs;
                SC_P1_LEFT:    if (!key_ext) kb_p1_next.dir[JOY_L] = key_prs;
                SC_P1_RIGHT:   if (!key_ext) kb_p1_next.dir[JOY_R] = key_prs;
                SC_P1_B0:      if (!key_ext) kb_p1_next.btn[0]     = key_prs;
                SC_P1_B1:      if (!key_ext) kb_p1_next.btn[1]     = key_prs;
                SC_P1_B2:      if (!key_ext) kb_p1_next.btn[2]     = key_prs;
                SC_P1_START:   if (!key_ext) kb_p1_next.start      = key_prs;
                SC_P1_COIN:    if (!key_ext) kb_p1_next.coin       = key_prs;
                SC_P1_SERVICE: if (!key_ext) kb_p1_next.service    = key_prs;
                default: ;
            endcase
        end
    end

    // Event arming, toggle history, keyboard state, vblank history
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            old_tog  <= 1'b0;
            armed    <= 1'b0;
            vblank_q <= 1'b0;
            kb_p0    <= '0;
            kb_p1    <= '0;
        end else begin
            old_tog  <= ps2_key[PS2_TOG];
            armed    <= 1'b1;
            vblank_q <= vblank;
            kb_p0    <= kb_p0_next;
            kb_p1    <= kb_p1_next;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam int unsigned BASE = player_base(p, JOY_WIDTH);

        key_state_t  kb;
        logic [3:0]  raw_dir;
        logic        raw_start;
        logic        raw_coin;
        logic        raw_pause;
        logic        raw_service;
        logic [3:0]  dir_q;
        logic        start_q;
        logic        service_q;
        logic        coin_q;
        logic        coin_prev;
        logic [15:0] coin_cnt;
        logic [15:0] coin_cnt_next;
        logic        pause_q;
        logic        pause_prev;

        if (p == 0) begin : g_kb0
            assign kb = kb_p0;
        end else if (p == 1) begin : g_kb1
            assign kb = kb_p1;
        end else begin : g_kbn
            assign kb = '0;
        end

        assign raw_dir     = {joystick[BASE + JOY_U], joystick[BASE + JOY_D],
                              joystick[BASE + JOY_L], joystick[BASE + JOY_R]} | kb.dir;
        assign raw_start   = joystick[BASE + joy_start(NUM_BUTTONS)]   | kb.start;
        assign raw_coin    = joystick[BASE + joy_coin(NUM_BUTTONS)]    | kb.coin;
        assign raw_pause   = joystick[BASE + joy_pause(NUM_BUTTONS)]   | kb.pause;
        assign raw_service = joystick[BASE + joy_service(NUM_BUTTONS)] | kb.service;

        // Coin stretch: load on a fresh edge only when idle, count down to zero
        always_comb begin
            coin_cnt_next = coin_cnt;
            if (coin_cnt != '0) begin
                coin_cnt_next = coin_cnt - 16'd1;
            end else if (raw_coin && !coin_prev) begin
                coin_cnt_next = COIN_PULSE_CYCLES;
            end
        end

        // Registered per-player strobes, coin counter and pause latch
        always_ff @(posedge clk_sys or posedge RESET) begin
            if (RESET) begin
                dir_q      <= '0;
                start_q    <= 1'b0;
                service_q  <= 1'b0;
                coin_q     <= 1'b0;
                coin_prev  <= 1'b0;
                coin_cnt   <= '0;
                pause_q    <= 1'b0;
                pause_prev <= 1'b0;
            end else begin
                dir_q      <= raw_dir;
                start_q    <= raw_start;
                service_q  <= raw_service;
                coin_prev  <= raw_coin;
                coin_cnt   <= coin_cnt_next;
                coin_q     <= (coin_cnt_next != '0) | raw_coin;
                pause_prev <= raw_pause;
                if (PAUSE_TOGGLE) begin
                    if (raw_pause && !pause_prev) pause_q <= ~pause_q;
                end else begin
                    pause_q <= raw_pause;
                end
            end
        end

        assign out_dir[p*4 +: 4] = dir_q;
        assign out_start[p]      = start_q;
        assign out_service[p]    = service_q;
        assign out_coin[p]       = coin_q;
        assign out_pause[p]      = pause_q;

        for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
            logic kb_btn;
            logic raw_btn;

            if (b < KEY_BUTTONS) begin : g_kb_btn
                assign kb_btn = kb.btn[b];
            end else begin : g_joy_only
                assign kb_btn = 1'b0;
            end

            assign raw_btn = joystick[BASE + JOY_BTN0 + b] | kb_btn;

            input_button_shaper #(
                .AUTOFIRE_FRAMES (AUTOFIRE_FRAMES)
            ) u_shaper (
                .clk_sys     (clk_sys),
                .RESET       (RESET),
                .raw         (raw_btn),
                .en          (autofire_en[p*NUM_BUTTONS + b]),
                .vblank_rise (vblank_rise),
                .shaped      (out_buttons[p*NUM_BUTTONS + b])
            );
        end
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: two instances differing only in pause mode.
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic [10:0] ps2_key;
    logic [21:0] joystick;
    logic        vblank;
    logic [5:0]  autofire_en;

    logic [7:0] out_dir,   out_dir_l;
    logic [5:0] out_buttons, out_buttons_l;
    logic [1:0] out_start, out_start_l;
    logic [1:0] out_coin,  out_coin_l;
    logic [1:0] out_pause, out_pause_l;
    logic [1:0] out_service, out_service_l;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(
        .NUM_PLAYERS(2), .NUM_BUTTONS(3), .JOY_WIDTH(11),
        .COIN_PULSE_CYCLES(16'd16), .AUTOFIRE_FRAMES(4'd2), .PAUSE_TOGGLE(1'b1)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joystick(joystick),
        .vblank(vblank), .autofire_en(autofire_en), .out_dir(out_dir),
        .out_buttons(out_buttons), .out_start(out_start), .out_coin(out_coin),
        .out_pause(out_pause), .out_service(out_service)
    );

    arcade_input_ctrl #(
        .NUM_PLAYERS(2), .NUM_BUTTONS(3), .JOY_WIDTH(11),
        .COIN_PULSE_CYCLES(16'd16), .AUTOFIRE_FRAMES(4'd2), .PAUSE_TOGGLE(1'b0)
    ) dut_lvl (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joystick(joystick),
        .vblank(vblank), .autofire_en(autofire_en), .out_dir(out_dir_l),
        .out_buttons(out_buttons_l), .out_start(out_start_l), .out_coin(out_coin_l),
        .out_pause(out_pause_l), .out_service(out_service_l)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_key(input logic prs, input logic ext, input logic [7:0] sc);
        ps2_key = {~ps2_key[10], prs, ext, sc};
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b1, 8'h75};
        joystick = '0;
        vblank = 1'b0;
        autofire_en = '0;
        tick(3);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if ({out_dir, out_buttons, out_start, out_coin, out_pause, out_service} !== e[21:0]) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h",
                     {out_dir, out_buttons, out_start, out_coin, out_pause, out_service}, e[21:0]);
        end
        RESET = 1'b0;
        tick(3);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if ({out_dir, out_buttons, out_start, out_coin, out_pause, out_service} !== e[21:0]) begin
            errors++;
            $display("FAIL arm_no_decode got %h want %h",
                     {out_dir, out_buttons, out_start, out_coin, out_pause, out_service}, e[21:0]);
        end
        send_key(1'b1, 1'b1, 8'h75);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        tick();
        e = exp_q.pop_front(); checks++;
        if (out_dir[3] !== e[0]) begin
            errors++; $display("FAIL p0_up_edge1 got %b want %b", out_dir[3], e[0]);
        end
        tick();
        e = exp_q.pop_front(); checks++;
        if (out_dir[3] !== e[0]) begin
            errors++; $display("FAIL p0_up_edge2 got %b want %b", out_dir[3], e[0]);
        end
        send_key(1'b0, 1'b1, 8'h75);
        exp_q.push_back(32'd0);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_dir[3] !== e[0]) begin
            errors++; $display("FAIL p0_up_release got %b want %b", out_dir[3], e[0]);
        end
    endtask

    task automatic test_extended;
        send_key(1'b1, 1'b0, 8'h75);
        exp_q.push_back(32'h0);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_dir !== e[7:0]) begin
            errors++; $display("FAIL keypad8_ignored got %h want %h", out_dir, e[7:0]);
        end
        send_key(1'b0, 1'b0, 8'h75);
        tick();
        send_key(1'b1, 1'b1, 8'h14);
        exp_q.push_back(32'd1);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_buttons[0] !== e[0]) begin
            errors++; $display("FAIL rctrl_b0 got %b want %b", out_buttons[0], e[0]);
        end
        send_key(1'b0, 1'b1, 8'h14);
        tick();
        send_key(1'b1, 1'b1, 8'h29);
        exp_q.push_back(32'h0);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_buttons !== e[5:0]) begin
            errors++; $display("FAIL ext_space_ignored got %h want %h", out_buttons, e[5:0]);
        end
        // back-to-back events on consecutive cycles
        send_key(1'b1, 1'b0, 8'h1C);
        tick();
        send_key(1'b1, 1'b0, 8'h1E);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_buttons[3] !== e[0]) begin
            errors++; $display("FAIL b2b_p1_b0 got %b want %b", out_buttons[3], e[0]);
        end
        e = exp_q.pop_front(); checks++;
        if (out_start[1] !== e[0]) begin
            errors++; $display("FAIL b2b_p1_start got %b want %b", out_start[1], e[0]);
        end
        send_key(1'b0, 1'b0, 8'h1C);
        tick();
        send_key(1'b0, 1'b0, 8'h1E);
        exp_q.push_back(32'h0);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if ({out_buttons, out_start} !== e[7:0]) begin
            errors++; $display("FAIL b2b_release got %h want %h", {out_buttons, out_start}, e[7:0]);
        end
    endtask

    task automatic test_coin;
        joystick[8] = 1'b1;
        tick();
        joystick[8] = 1'b0;
        for (int i = 0; i < 20; i++) exp_q.push_back(32'(i < 16));
        for (int i = 0; i < 20; i++) begin
            e = exp_q.pop_front(); checks++;
            if (out_coin[0] !== e[0]) begin
                errors++; $display("FAIL coin_single cyc %0d got %b want %b", i, out_coin[0], e[0]);
            end
            tick();
        end
        joystick[8] = 1'b1;
        tick();
        joystick[8] = 1'b0;
        for (int i = 0; i < 20; i++) exp_q.push_back(32'(i < 16));
        for (int i = 0; i < 20; i++) begin
            e = exp_q.pop_front(); checks++;
            if (out_coin[0] !== e[0]) begin
                errors++; $display("FAIL coin_repress cyc %0d got %b want %b", i, out_coin[0], e[0]);
            end
            joystick[8] = (i == 7);
            tick();
        end
    endtask

    task automatic test_pause;
        logic [1:0] want [4];
        want[0] = 2'b11; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            send_key(1'(i % 2 == 0), 1'b0, 8'h4D);
            exp_q.push_back(32'(want[i]));
            tick(2);
            e = exp_q.pop_front(); checks++;
            if ({out_pause[0], out_pause_l[0]} !== e[1:0]) begin
                errors++;
                $display("FAIL pause step %0d got tog=%b lvl=%b want tog=%b lvl=%b",
                         i, out_pause[0], out_pause_l[0], e[1], e[0]);
            end
        end
    endtask

    task automatic test_autofire;
        autofire_en[4] = 1'b1;
        send_key(1'b1, 1'b0, 8'h1B);
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        tick(2);
        for (int f = 0; f < 7; f++) begin
            if (f > 0) begin
                vblank = 1'b1;
                tick();
                vblank = 1'b0;
                tick(3);
            end
            e = exp_q.pop_front(); checks++;
            if (out_buttons[4] !== e[0]) begin
                errors++; $display("FAIL autofire frame %0d got %b want %b", f, out_buttons[4], e[0]);
            end
        end
        send_key(1'b0, 1'b0, 8'h1B);
        exp_q.push_back(32'd0);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_buttons[4] !== e[0]) begin
            errors++; $display("FAIL autofire_key_release got %b want %b", out_buttons[4], e[0]);
        end
        // press coincident with a vblank edge must not count that edge
        joystick[16] = 1'b1;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_buttons[4] !== e[0]) begin
            errors++; $display("FAIL coincident_press got %b want %b", out_buttons[4], e[0]);
        end
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_buttons[4] !== e[0]) begin
            errors++; $display("FAIL coincident_first_frame got %b want %b", out_buttons[4], e[0]);
        end
        joystick[16] = 1'b0;
        tick();
        e = exp_q.pop_front(); checks++;
        if (out_buttons[4] !== e[0]) begin
            errors++; $display("FAIL autofire_joy_release got %b want %b", out_buttons[4], e[0]);
        end
        autofire_en[4] = 1'b0;
    endtask

    task automatic test_merge;
        send_key(1'b1, 1'b0, 8'h14);
        joystick[4] = 1'b1;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_buttons[0] !== e[0]) begin
            errors++; $display("FAIL merge_both got %b want %b", out_buttons[0], e[0]);
        end
        send_key(1'b0, 1'b0, 8'h14);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_buttons[0] !== e[0]) begin
            errors++; $display("FAIL merge_key_released got %b want %b", out_buttons[0], e[0]);
        end
        joystick[4] = 1'b0;
        tick();
        e = exp_q.pop_front(); checks++;
        if (out_buttons[0] !== e[0]) begin
            errors++; $display("FAIL merge_all_released got %b want %b", out_buttons[0], e[0]);
        end
        send_key(1'b1, 1'b0, 8'h2D);
        joystick[11] = 1'b1;
        exp_q.push_back(32'h90);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (out_dir !== e[7:0]) begin
            errors++; $display("FAIL p1_dirs got %h want %h", out_dir, e[7:0]);
        end
        send_key(1'b0, 1'b0, 8'h2D);
        joystick[11] = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid;
        send_key(1'b1, 1'b0, 8'h4D);
        tick(2);
        joystick[8] = 1'b1;
        tick();
        joystick[8] = 1'b0;
        tick(3);
        RESET = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if ({out_coin[0], out_pause[0]} !== e[1:0]) begin
            errors++; $display("FAIL reset_async got coin=%b pause=%b want 0", out_coin[0], out_pause[0]);
        end
        tick(2);
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(32'h0);
            tick();
            e = exp_q.pop_front(); checks++;
            if ({out_coin[0], out_pause[0]} !== e[1:0]) begin
                errors++;
                $display("FAIL post_reset cyc %0d got coin=%b pause=%b want 0", i, out_coin[0], out_pause[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_extended();
        test_coin();
        test_pause();
        test_autofire();
        test_merge();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
